// File: rtl/timer_arbiter_pkg.sv
// Shared constants, bus-write record and FSM states for the interval-timer arbiter.
package timer_arbiter_pkg;

  // Interval timer register map (16-bit layout).
  localparam logic [2:0] TMR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_PERIODH = 3'd3;

  // Control words: one-shot start with interrupt enabled, and stop.
  localparam logic [15:0] CTRL_GO   = 16'h0005;
  localparam logic [15:0] CTRL_STOP = 16'h0008;

  // One cycle of the write-only timer master port.
  typedef struct packed {
    logic        cs;
    logic [2:0]  addr;
    logic [15:0] data;
  } tmr_wr_t;

  localparam tmr_wr_t TMR_BUS_IDLE = '{cs: 1'b0, addr: 3'd0, data: 16'd0};

  typedef enum logic [3:0] {
    S_INIT_STOP,
    S_INIT_CLR,
    S_IDLE,
    S_ARB,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTRL,
    S_WAIT,
    S_CLR,
    S_DONE,
    S_CANCEL,
    S_CLR_C
  } state_e;

  function automatic tmr_wr_t tmr_wr(input logic [2:0] addr, input logic [15:0] data);
    return '{cs: 1'b1, addr: addr, data: data};
  endfunction

endpackage

// File: rtl/timer_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester at or after ptr, wrapping.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic         valid,
  output logic [2:0]   id
);

  logic       any_found;
  logic [2:0] any_id;
  logic       upper_found;
  logic [2:0] upper_id;

  // Scan downwards so the last hit is the lowest index, both overall and at/after ptr.
  // NOTE: every variable gets a default before the scan, otherwise it would infer a latch.
  always_comb begin
    any_found   = 1'b0;
    any_id      = 3'd0;
    upper_found = 1'b0;
    upper_id    = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_found = 1'b1;
        any_id    = 3'(i);
        if (3'(i) >= ptr) begin
          upper_found = 1'b1;
          upper_id    = 3'(i);
        end
      end
    end
    valid = any_found;
    id    = upper_found ? upper_id : any_id;
  end

endmodule

// File: rtl/timer_arbiter.sv
// Shares one interval timer among NUM_REQ one-shot delay clients, round-robin.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [32*NUM_REQ-1:0] req_ticks,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic [2:0]           active_id,
  output logic [2:0]           tmr_address,
  output logic                 tmr_chipselect,
  output logic                 tmr_write_n,
  output logic [15:0]          tmr_writedata,
  input  logic                 tmr_irq
);

  state_e       state_q, state_d;
  logic [2:0]   id_q, id_d;
  logic [2:0]   ptr_q, ptr_d;
  logic [31:0]  load_q, load_d;
  tmr_wr_t      bus_q, bus_d;
  logic [NUM_REQ-1:0] done_d;
  logic         busy_q;

  logic         pick_valid;
  logic [2:0]   pick_id;
  logic [7:0]   req_ext;
  logic [7:0]   done_ext;
  logic [31:0]  ticks_arr [8];

  // Pad per-client views to 8 entries so 3-bit ids index them exactly.
  assign req_ext = 8'(req);
  for (genvar g = 0; g < 8; g++) begin : g_ticks
    if (g < NUM_REQ) begin : g_in
      assign ticks_arr[g] = req_ticks[32*g +: 32];
    end else begin : g_pad
      assign ticks_arr[g] = 32'd0;
    end
  end

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .id    (pick_id)
  );

  // Next-state and grant bookkeeping.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    load_d  = load_q;
    unique case (state_q)
      // The bus register is forced idle by reset, so stay here until the stop write is actually out.
      S_INIT_STOP: if (bus_q.cs) state_d = S_INIT_CLR;
      S_INIT_CLR:  state_d = S_IDLE;
      S_IDLE:      if (|req) state_d = S_ARB;
      S_ARB: begin
        if (pick_valid) begin
          id_d  = pick_id;
          ptr_d = (int'(pick_id) == NUM_REQ - 1) ? 3'd0 : pick_id + 3'd1;
          if (ticks_arr[pick_id] == 32'd0) begin
            state_d = S_DONE;
          end else begin
            load_d  = ticks_arr[pick_id] - 32'd1;
            state_d = S_WR_PL;
          end
        end else begin
          // Every request vanished between IDLE and ARB: nothing to grant.
          state_d = S_IDLE;
        end
      end
      S_WR_PL:   state_d = S_WR_PH;
      S_WR_PH:   state_d = S_WR_CTRL;
      S_WR_CTRL: state_d = S_WAIT;
      S_WAIT: begin
        if (!req_ext[id_q])  state_d = S_CANCEL;
        else if (tmr_irq)    state_d = S_CLR;
      end
      S_CLR:    state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      S_CANCEL: state_d = S_CLR_C;
      S_CLR_C:  state_d = S_IDLE;
      default:  state_d = S_INIT_STOP;
    endcase
  end

  // Output decode of the state being entered, so registered outputs line up with the state.
  always_comb begin
    bus_d    = TMR_BUS_IDLE;
    done_ext = 8'd0;
    unique case (state_d)
      S_INIT_STOP, S_CANCEL:       bus_d = tmr_wr(TMR_CONTROL, CTRL_STOP);
      S_INIT_CLR, S_CLR, S_CLR_C:  bus_d = tmr_wr(TMR_STATUS, 16'd0);
      S_WR_PL:                     bus_d = tmr_wr(TMR_PERIODL, load_d[15:0]);
      S_WR_PH:                     bus_d = tmr_wr(TMR_PERIODH, load_d[31:16]);
      S_WR_CTRL:                   bus_d = tmr_wr(TMR_CONTROL, CTRL_GO);
      S_DONE:                      done_ext[id_d] = 1'b1;
      default:                     bus_d = TMR_BUS_IDLE;
    endcase
    done_d = done_ext[NUM_REQ-1:0];
  end

  // State and output registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT_STOP;
      id_q    <= 3'd0;
      ptr_q   <= 3'd0;
      load_q  <= 32'd0;
      bus_q   <= TMR_BUS_IDLE;
      done    <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      load_q  <= load_d;
      bus_q   <= bus_d;
      done    <= done_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign busy           = busy_q;
  assign active_id      = id_q;
  assign tmr_chipselect = bus_q.cs;
  assign tmr_write_n    = ~bus_q.cs;
  assign tmr_address    = bus_q.addr;
  assign tmr_writedata  = bus_q.data;

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter with a behavioural interval-timer slave.
module tb_timer_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req = '0;
  logic [127:0] req_ticks = '0;
  logic [3:0]   done;
  logic         busy;
  logic [2:0]   active_id;
  logic [2:0]   tmr_address;
  logic         tmr_chipselect;
  logic         tmr_write_n;
  logic [15:0]  tmr_writedata;
  logic         tmr_irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ptr = 0;

  logic [18:0] bus_log[$];
  int          bus_cyc[$];
  int          done_log[$];
  int          done_cyc[$];
  logic [18:0] exp_bus[$];
  int          exp_done[$];

  timer_arbiter #(.NUM_REQ(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_ticks      (req_ticks),
    .done           (done),
    .busy           (busy),
    .active_id      (active_id),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_irq        (tmr_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Interval timer slave: one-shot counts load..0 after START, then sets TO.
  logic [15:0] t_pl = '0, t_ph = '0;
  logic [31:0] t_cnt = '0;
  logic        t_run = 1'b0, t_to = 1'b0, t_ito = 1'b0;
  assign tmr_irq = t_to & t_ito;

  always @(posedge clk) begin
    if (tmr_chipselect && !tmr_write_n) begin
      case (tmr_address)
        3'd0: t_to <= 1'b0;
        3'd1: begin
          t_ito <= tmr_writedata[0];
          if (tmr_writedata[3]) t_run <= 1'b0;
          else if (tmr_writedata[2]) begin
            t_run <= 1'b1;
            t_cnt <= {t_ph, t_pl};
          end
        end
        3'd2: t_pl <= tmr_writedata;
        3'd3: t_ph <= tmr_writedata;
        default: ;
      endcase
    end else if (t_run) begin
      if (t_cnt == 0) begin
        t_to  <= 1'b1;
        t_run <= 1'b0;
      end else begin
        t_cnt <= t_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus and done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset && cyc > 1) begin
      if (tmr_chipselect === 1'b1) begin
        bus_log.push_back({tmr_address, tmr_writedata});
        bus_cyc.push_back(cyc);
        check("write_n_low", {31'd0, tmr_write_n}, 32'd0);
      end else begin
        check("idle_bus", {12'd0, tmr_write_n, tmr_address, tmr_writedata}, {12'd0, 1'b1, 3'd0, 16'd0});
      end
      if (done !== 4'd0) begin
        check("done_onehot", {31'd0, $onehot(done)}, 32'd1);
        for (int i = 0; i < 4; i++) if (done[i]) begin
          done_log.push_back(i);
          done_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic clear_logs();
    bus_log.delete(); bus_cyc.delete(); done_log.delete(); done_cyc.delete();
    exp_bus.delete(); exp_done.delete();
  endtask

  // Reference: writes a grant must produce, and the rotating pointer.
  task automatic exp_grant(input int id, input bit completes);
    logic [31:0] t, ld;
    t = req_ticks[32*id +: 32];
    ld = t - 32'd1;
    if (t != 0) begin
      exp_bus.push_back({3'd2, ld[15:0]});
      exp_bus.push_back({3'd3, ld[31:16]});
      exp_bus.push_back({3'd1, 16'h0005});
    end
    if (completes) begin
      if (t != 0) exp_bus.push_back({3'd0, 16'h0000});
      exp_done.push_back(id);
    end else begin
      exp_bus.push_back({3'd1, 16'h0008});
      exp_bus.push_back({3'd0, 16'h0000});
    end
    ptr = (id + 1) % 4;
  endtask

  // Grant order for a set of held requests, with optional one-time re-requests after done.
  task automatic plan(input logic [3:0] mask, input logic [3:0] re_in);
    logic [3:0] pend, re;
    int id;
    pend = mask;
    re = re_in;
    while (pend != 0) begin
      id = -1;
      for (int k = 0; k < 4; k++) if (id < 0 && pend[(ptr + k) % 4]) id = (ptr + k) % 4;
      exp_grant(id, 1'b1);
      pend[id] = 1'b0;
      if (re[id]) begin pend[id] = 1'b1; re[id] = 1'b0; end
    end
  endtask

  task automatic cmp_logs(input string tag);
    check({tag, "_ndone"}, done_log.size(), exp_done.size());
    for (int i = 0; i < done_log.size() && i < exp_done.size(); i++)
      check({tag, "_done_id"}, done_log[i], exp_done[i]);
    check({tag, "_nwrites"}, bus_log.size(), exp_bus.size());
    for (int i = 0; i < bus_log.size() && i < exp_bus.size(); i++)
      check({tag, "_write"}, {13'd0, bus_log[i]}, {13'd0, exp_bus[i]});
  endtask

  task automatic wait_idle(input string tag, output int when);
    int n;
    n = 0;
    when = -1;
    while (n < 50) begin
      @(negedge clk); n++;
      if (!busy) begin when = cyc; break; end
    end
    check({tag, "_idle_timeout"}, {31'd0, (when >= 0)}, 32'd1);
  endtask

  task automatic run_until_idle(input logic [3:0] re_in, input int budget);
    logic [3:0] re, pend;
    int n;
    re = re_in; pend = '0; n = 0;
    while (n < budget) begin
      @(negedge clk); n++;
      req = req | pend;
      pend = '0;
      for (int i = 0; i < 4; i++) if (done[i]) begin
        req[i] = 1'b0;
        if (re[i]) begin pend[i] = 1'b1; re[i] = 1'b0; end
      end
      if (req == 0 && pend == 0 && !busy) break;
    end
    check("run_timeout", {31'd0, (n < budget)}, 32'd1);
  endtask

  task automatic wait_ctrl_go(input string tag);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (n < 30 && !seen) begin
      @(negedge clk); n++;
      seen = (tmr_chipselect && tmr_address == 3'd1 && tmr_writedata == 16'h0005);
    end
    check({tag, "_go_seen"}, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int r, irq_c, n, when;
    bit seen;
    logic [3:0] mask, re;

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    check("rst_cs", {31'd0, tmr_chipselect}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_done", {28'd0, done}, 32'd0);
    check("rst_active_id", {29'd0, active_id}, 32'd0);

    // Reset release: stop, clear, then busy drops one cycle after the clear.
    clear_logs();
    reset = 1'b0;
    ptr = 0;
    wait_idle("init", when);
    exp_bus.push_back({3'd1, 16'h0008});
    exp_bus.push_back({3'd0, 16'h0000});
    cmp_logs("init");
    if (bus_cyc.size() == 2) check("init_busy_fall", when - bus_cyc[1], 1);

    // Client 2 with 50000 ticks.
    clear_logs();
    req_ticks[64 +: 32] = 32'd50000;
    exp_grant(2, 1'b1);
    req[2] = 1'b1;
    r = cyc;
    n = 0; irq_c = -1;
    while (n < 60000 && !done[2]) begin
      @(negedge clk); n++;
      if (tmr_irq && irq_c < 0) irq_c = cyc;
      if (n == 100) check("long_active_id", {28'd0, busy, active_id}, {28'd0, 1'b1, 3'd2});
    end
    check("long_done_timeout", {31'd0, done[2]}, 32'd1);
    req[2] = 1'b0;
    @(negedge clk);
    cmp_logs("long");
    if (bus_cyc.size() == 4 && done_cyc.size() == 1) begin
      check("long_first_write", bus_cyc[0] - r, 2);
      check("long_irq_to_clr", bus_cyc[3] - irq_c, 1);
      check("long_clr_to_done", done_cyc[0] - bus_cyc[3], 1);
    end

    // All four together, ticks=10, client 0 re-requests after its done.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ptr = 0;
    wait_idle("rst2", when);
    clear_logs();
    for (int i = 0; i < 4; i++) req_ticks[32*i +: 32] = 32'd10;
    plan(4'hF, 4'h1);
    req = 4'hF;
    run_until_idle(4'h1, 1000);
    cmp_logs("rr");

    // Zero ticks: done two cycles after the request, no timer access.
    clear_logs();
    req_ticks[32 +: 32] = 32'd0;
    plan(4'h2, 4'h0);
    req[1] = 1'b1;
    r = cyc;
    run_until_idle(4'h0, 50);
    cmp_logs("zero");
    if (done_cyc.size() == 1) check("zero_latency", done_cyc[0] - r, 2);

    // Client 0 cancels in WAIT; pending client 1 is granted next.
    clear_logs();
    req_ticks[0 +: 32] = 32'd1000;
    req_ticks[32 +: 32] = 32'd5;
    exp_grant(0, 1'b0);
    exp_grant(1, 1'b1);
    req[0] = 1'b1;
    wait_ctrl_go("cancel");
    repeat (20) @(negedge clk);
    req[1] = 1'b1;
    repeat (5) @(negedge clk);
    req[0] = 1'b0;
    run_until_idle(4'h0, 500);
    cmp_logs("cancel");

    // irq and request drop in the same WAIT cycle: cancel wins.
    clear_logs();
    req_ticks[96 +: 32] = 32'd30;
    exp_grant(3, 1'b0);
    req[3] = 1'b1;
    n = 0; seen = 0;
    while (n < 200 && !seen) begin
      @(negedge clk); n++;
      seen = tmr_irq;
    end
    check("tie_irq_seen", {31'd0, seen}, 32'd1);
    req[3] = 1'b0;
    run_until_idle(4'h0, 100);
    cmp_logs("tie");

    // Reset in the middle of WAIT: bus idle at once, INIT sequence reruns.
    clear_logs();
    req_ticks[0 +: 32] = 32'd200;
    req[0] = 1'b1;
    wait_ctrl_go("midrst");
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_cs", {31'd0, tmr_chipselect}, 32'd0);
    check("midrst_busy_done", {27'd0, busy, done}, {27'd0, 1'b1, 4'd0});
    req = '0;
    @(negedge clk);
    reset = 1'b0;
    ptr = 0;
    clear_logs();
    wait_idle("midrst", when);
    exp_bus.push_back({3'd1, 16'h0008});
    exp_bus.push_back({3'd0, 16'h0000});
    cmp_logs("midrst");

    // Randomised rounds of held requests against the round-robin model.
    for (int round = 0; round < 8; round++) begin
      clear_logs();
      for (int i = 0; i < 4; i++) req_ticks[32*i +: 32] = 32'($urandom_range(0, 12));
      mask = 4'($urandom_range(1, 15));
      re = mask & 4'($urandom_range(0, 15));
      plan(mask, re);
      req = mask;
      run_until_idle(re, 2000);
      cmp_logs("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
